binary_attn_value: RTL and testbench

BINARY_ATTN_VALUE -- requirements
Module: binary_attn_value

---
 rtl/binary_attn_value.sv | 147 ++++++++++++++
 tb/tb_binary_attn_value.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/binary_attn_value.sv
// Binary attention value stage: accumulates +/-1 votes of selected value bits per head
// over one score row, then emits the sign of each counter as a single output word.
module binary_attn_value #(
    parameter int SEQ_LEN  = 30,
    parameter int N_HEADS  = 4,
    parameter int HEAD_DIM = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [SEQ_LEN-1:0]            score_h1,
    input  logic [SEQ_LEN-1:0]            score_h2,
    input  logic [SEQ_LEN-1:0]            score_h3,
    input  logic [SEQ_LEN-1:0]            score_h4,
    input  logic [SEQ_LEN*N_HEADS*HEAD_DIM-1:0] value_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [N_HEADS*HEAD_DIM-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          done
);

    localparam int D  = N_HEADS * HEAD_DIM;
    localparam int KW = $clog2(SEQ_LEN + 1);
    localparam int CW = 6;

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT, FINISHED} state_t;

    state_t                state_r;
    logic [KW-1:0]         k_r;
    logic [KW-1:0]         row_cnt_r;
    logic [SEQ_LEN-1:0]    score_r [4];
    logic [SEQ_LEN*D-1:0]  value_r;
    logic signed [CW-1:0]  cnt_r [D];

    logic [SEQ_LEN-1:0]    score_in_s [4];
    logic [KW-1:0]         k_sel_s;
    logic [D-1:0]          key_val_s;
    logic signed [CW-1:0]  cnt_next_s [D];
    logic [D-1:0]          pos_s;

    assign score_in_s[0] = score_h1;
    assign score_in_s[1] = score_h2;
    assign score_in_s[2] = score_h3;
    assign score_in_s[3] = score_h4;

    // Per-key counter update; k equal to SEQ_LEN is the final compare cycle, so clamp the index.
    always_comb begin
        if (k_r < KW'(SEQ_LEN)) begin
            k_sel_s = k_r;
        end else begin
            k_sel_s = {KW{1'b0}};
        end
        key_val_s = value_r[k_sel_s*D +: D];
        for (int i = 0; i < D; i++) begin
            cnt_next_s[i] = cnt_r[i];
            pos_s[i]      = (cnt_r[i] > 6'sd0);
            if (score_r[i/HEAD_DIM][k_sel_s]) begin
                if (key_val_s[i]) begin
                    cnt_next_s[i] = cnt_r[i] + 6'sd1;
                end else begin
                    cnt_next_s[i] = cnt_r[i] - 6'sd1;
                end
            end else begin
                cnt_next_s[i] = cnt_r[i];
            end
        end
    end

    // Control FSM with registered handshake outputs and the accumulation datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            k_r       <= {KW{1'b0}};
            row_cnt_r <= {KW{1'b0}};
            value_r   <= {(SEQ_LEN*D){1'b0}};
            out_data  <= {D{1'b0}};
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            done      <= 1'b0;
            for (int h = 0; h < 4; h++) begin
                score_r[h] <= {SEQ_LEN{1'b0}};
            end
            for (int i = 0; i < D; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    if (in_valid && in_ready) begin
                        for (int h = 0; h < 4; h++) begin
                            score_r[h] <= score_in_s[h];
                        end
                        for (int i = 0; i < D; i++) begin
                            cnt_r[i] <= {CW{1'b0}};
                        end
                        value_r  <= value_in;
                        k_r      <= {KW{1'b0}};
                        in_ready <= 1'b0;
                        state_r  <= ACCUM;
                    end
                end
                ACCUM: begin
                    in_ready <= 1'b0;
                    if (k_r == KW'(SEQ_LEN)) begin
                        out_data  <= pos_s;
                        out_valid <= 1'b1;
                        state_r   <= EMIT;
                    end else begin
                        for (int i = 0; i < D; i++) begin
                            cnt_r[i] <= cnt_next_s[i];
                        end
                        k_r <= k_r + KW'(1);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        row_cnt_r <= row_cnt_r + KW'(1);
                        if (row_cnt_r == KW'(SEQ_LEN - 1)) begin
                            done    <= 1'b1;
                            state_r <= FINISHED;
                        end else begin
                            in_ready <= 1'b1;
                            state_r  <= IDLE;
                        end
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                FINISHED: begin
                    done      <= 1'b1;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_attn_value.sv
// Directed bench for binary_attn_value: scoreboard queue of expected words, latency,
// back-pressure, mid-row reset and end-of-sequence behaviour.
module tb_binary_attn_value;

    localparam int SEQ_LEN = 30;
    localparam int D       = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [SEQ_LEN-1:0]   score_h1, score_h2, score_h3, score_h4;
    logic [SEQ_LEN*D-1:0] value_in;
    logic                 in_valid, in_ready;
    logic [D-1:0]         out_data;
    logic                 out_valid, out_ready, done;

    int         checks    = 0;
    int         errors    = 0;
    int         rows_done = 0;
    logic [D-1:0] exp_q [$];

    always #5 clk = ~clk;

    binary_attn_value #(.SEQ_LEN(SEQ_LEN), .N_HEADS(4), .HEAD_DIM(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .score_h1(score_h1), .score_h2(score_h2), .score_h3(score_h3), .score_h4(score_h4),
        .value_in(value_in), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: sum +/-1 over selected keys with plain integers, output = sum > 0.
    function automatic logic [D-1:0] model(input logic [3:0][SEQ_LEN-1:0] sc,
                                           input logic [SEQ_LEN*D-1:0] v);
        logic [D-1:0] r;
        for (int i = 0; i < D; i++) begin
            int c = 0;
            for (int k = 0; k < SEQ_LEN; k++) begin
                if (sc[i/4][k]) c += v[k*D+i] ? 1 : -1;
            end
            r[i] = (c > 0);
        end
        return r;
    endfunction

    function automatic logic [SEQ_LEN*D-1:0] rand_vals();
        logic [SEQ_LEN*D-1:0] v;
        for (int j = 0; j < SEQ_LEN*D/32; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic scramble();
        score_h1 = SEQ_LEN'($urandom); score_h2 = SEQ_LEN'($urandom);
        score_h3 = SEQ_LEN'($urandom); score_h4 = SEQ_LEN'($urandom);
        value_in = rand_vals();
    endtask

    task automatic send_row(input logic [3:0][SEQ_LEN-1:0] sc, input logic [SEQ_LEN*D-1:0] v,
                            input logic [D-1:0] expv);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("accept_wait", 32'(w < 100), 32'd1);
        score_h1 = sc[0]; score_h2 = sc[1]; score_h3 = sc[2]; score_h4 = sc[3];
        value_in = v;
        in_valid = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic get_out(input int stall);
        int c = 0;
        logic [D-1:0] expv, held;
        while (!out_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("latency", 32'(c), 32'd31);
        check("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : {D{1'b0}};
        check("out_data", 32'(out_data), 32'(expv));
        check("in_ready_emit", 32'(in_ready), 32'd0);
        held = out_data;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(held));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        rows_done++;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("done", 32'(done), 32'(rows_done == SEQ_LEN));
        check("in_ready_after", 32'(in_ready), 32'(rows_done != SEQ_LEN));
    endtask

    initial begin
        logic [3:0][SEQ_LEN-1:0] sc;
        logic [SEQ_LEN*D-1:0]    v;
        int bad;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_rise", 32'(in_ready), 32'd1);

        // All scores zero: every counter stays 0.
        sc = '0;
        send_row(sc, rand_vals(), 16'h0000);
        get_out(0);

        // Single key, all ones on head 0 only.
        sc = '0; sc[0] = 30'h1; v = '0; v[15:0] = 16'hFFFF;
        send_row(sc, v, 16'h000F);
        get_out(0);

        // Tie on bit 0 gives 0; bits 1..3 see two zeros.
        sc = '0; sc[0] = 30'h3; v = '0; v[0] = 1'b1;
        send_row(sc, v, 16'h0000);
        get_out(0);

        // Three keys, two ones on bit 0.
        sc = '0; sc[0] = 30'h7; v = '0; v[0] = 1'b1; v[2*D] = 1'b1;
        send_row(sc, v, 16'h0001);
        get_out(5);

        // Random row, with back-pressure.
        for (int h = 0; h < 4; h++) sc[h] = SEQ_LEN'($urandom);
        v = rand_vals();
        send_row(sc, v, model(sc, v));
        get_out(5);

        // Reset in the middle of accumulation discards the row.
        for (int h = 0; h < 4; h++) sc[h] = SEQ_LEN'($urandom);
        send_row(sc, rand_vals(), 16'h0000);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        exp_q.delete();
        rows_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready_rise", 32'(in_ready), 32'd1);
        check("midrst_no_output", 32'(out_valid), 32'd0);

        // Full sequence of SEQ_LEN rows after the reset.
        for (int r = 0; r < SEQ_LEN; r++) begin
            for (int h = 0; h < 4; h++) sc[h] = SEQ_LEN'($urandom);
            v = rand_vals();
            send_row(sc, v, model(sc, v));
            get_out(0);
        end

        // Further requests are never accepted once finished.
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b1) bad++;
        end
        in_valid = 1'b0;
        check("finished_ignores_input", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
